// File: rtl/carregador_programa.sv
// carregador_programa: program loader and run sequencer for the SAP-1 core.
// Streams bytes into the 16x8 program RAM from address 0, holds the CPU in
// reset while loading, then releases it into execution and tracks HLT so a
// new program can be loaded without a board-level reset.
//
// Handshake: a byte transfers on a rising CLK edge where byte_valid and
// byte_ready are both 1. byte_ready is decoded from the state alone (high
// only in LOAD), so it never depends on byte_valid; the producer may hold
// byte_valid/byte_data/byte_last steady until the transfer happens.
module carregador_programa #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int CLR_HOLD = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              cpu_halt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic              run_prog,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        state_dbg
);

    // Hold counter is wide enough for CLR_HOLD and never narrower than 1 bit.
    localparam int HOLD_W = (CLR_HOLD < 2) ? 1 : $clog2(CLR_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CLR_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ADDR_W-1:0] PTR_MAX   = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_FLUSH  = 3'd2,
        S_RUN    = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic [ADDR_W-1:0]   ram_addr_nxt;
    logic [DATA_W-1:0]   ram_data_nxt;
    logic                ram_we_nxt;
    logic                run_prog_nxt;
    logic                cpu_clr_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic [ADDR_W:0]     word_count_nxt;
    logic                accept;
    logic                load_end;

    // The only unregistered output: ready follows the state directly.
    assign byte_ready = (state == S_LOAD);
    assign accept     = byte_ready && byte_valid;
    // The last slot (pointer at its maximum) ends the load even without byte_last,
    // so the pointer can never wrap onto address 0 within one load.
    assign load_end   = byte_last || (ptr == PTR_MAX);
    assign state_dbg  = state;

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        hold_cnt_nxt   = hold_cnt;
        ram_addr_nxt   = ram_addr;
        ram_data_nxt   = ram_data;
        ram_we_nxt     = 1'b0;
        run_prog_nxt   = run_prog;
        cpu_clr_nxt    = cpu_clr;
        busy_nxt       = busy;
        done_nxt       = done;
        word_count_nxt = word_count;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt      = S_LOAD;
                    ptr_nxt        = '0;
                    word_count_nxt = '0;
                    busy_nxt       = 1'b1;
                end
            end

            S_LOAD: begin
                // start is deliberately ignored here: a reload cannot
                // restart a load that is already in progress.
                if (accept) begin
                    ram_addr_nxt   = ptr;
                    ram_data_nxt   = byte_data;
                    ram_we_nxt     = 1'b1;
                    word_count_nxt = word_count + 1'b1;
                    if (load_end) begin
                        state_nxt    = S_FLUSH;
                        hold_cnt_nxt = HOLD_INIT;
                    end else begin
                        ptr_nxt = ptr + 1'b1;
                    end
                end
            end

            S_FLUSH: begin
                // The final strobe drains on the first FLUSH edge (ram_we
                // defaults to 0); the CPU is released CLR_HOLD edges after
                // the last accept.
                if (hold_cnt <= HOLD_ONE) begin
                    hold_cnt_nxt = '0;
                    state_nxt    = S_RUN;
                    run_prog_nxt = 1'b1;
                    cpu_clr_nxt  = 1'b1;
                    busy_nxt     = 1'b0;
                end else begin
                    hold_cnt_nxt = hold_cnt - 1'b1;
                end
            end

            S_RUN: begin
                // Reload wins over halt when both arrive together.
                if (start) begin
                    state_nxt      = S_LOAD;
                    ptr_nxt        = '0;
                    word_count_nxt = '0;
                    run_prog_nxt   = 1'b0;
                    cpu_clr_nxt    = 1'b0;
                    done_nxt       = 1'b0;
                    busy_nxt       = 1'b1;
                end else if (cpu_halt) begin
                    state_nxt = S_HALTED;
                    done_nxt  = 1'b1;
                end
            end

            S_HALTED: begin
                // run_prog/cpu_clr keep their RUN values so the halted CPU
                // state stays observable until a reload.
                if (start) begin
                    state_nxt      = S_LOAD;
                    ptr_nxt        = '0;
                    word_count_nxt = '0;
                    run_prog_nxt   = 1'b0;
                    cpu_clr_nxt    = 1'b0;
                    done_nxt       = 1'b0;
                    busy_nxt       = 1'b1;
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                run_prog_nxt = 1'b0;
                cpu_clr_nxt  = 1'b0;
                busy_nxt     = 1'b0;
                done_nxt     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; CLR low clears everything at once,
    // including an in-flight write strobe.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= S_IDLE;
            ptr        <= '0;
            hold_cnt   <= '0;
            ram_addr   <= '0;
            ram_data   <= '0;
            ram_we     <= 1'b0;
            run_prog   <= 1'b0;
            cpu_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            hold_cnt   <= hold_cnt_nxt;
            ram_addr   <= ram_addr_nxt;
            ram_data   <= ram_data_nxt;
            ram_we     <= ram_we_nxt;
            run_prog   <= run_prog_nxt;
            cpu_clr    <= cpu_clr_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            word_count <= word_count_nxt;
        end
    end

endmodule

// File: doc/carregador_programa.md
# carregador_programa

Program loader and run sequencer for the SAP-1 core. It accepts a byte stream over a valid/ready handshake and writes it into the 16×8 program RAM starting at address 0. While loading, it owns the RAM programming port and the `run_prog` mode line and holds the CPU in reset. Once loading ends it releases the CPU into execution and tracks halt, so a program can be reloaded without a board-level reset.

## Interface
- `ADDR_W`, default 4: RAM address width; depth is 2^ADDR_W = 16 words.
- `DATA_W`, default 8: RAM word width.
- `CLR_HOLD`, default 2: cycles the CPU reset stays asserted after the last load write. Must be ≥1.

- `CLK` in 1: single system clock, rising edge.
- `CLR` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a (re)load. Level-sampled each cycle.
- `byte_valid` in 1: a program byte is present on `byte_data`.
- `byte_data` in DATA_W: program byte.
- `byte_last` in 1: qualifies the current byte as the final one of the program.
- `byte_ready` out 1: loader can accept a byte this cycle.
- `cpu_halt` in 1: HLT decoded by the control unit.
- `ram_addr` out ADDR_W: RAM write address.
- `ram_data` out DATA_W: RAM write data.
- `ram_we` out 1: one-cycle RAM write strobe.
- `run_prog` out 1: 0 = program mode, 1 = execute; drives the RAM/MAR mode select.
- `cpu_clr` out 1: active-low reset to the CPU (PC, IR, control ring).
- `busy` out 1: high in LOAD or FLUSH.
- `done` out 1: high in HALTED.
- `word_count` out ADDR_W+1: bytes accepted in the current/last load, range 0..16.

## Operation
- States are IDLE, LOAD, FLUSH, RUN and HALTED. All outputs are registered except `byte_ready`, which is decoded from the state.
- **IDLE:**
  - Outputs: `run_prog`=0, `cpu_clr`=0, `byte_ready`=0.
  - `start`=1 → LOAD; clears `word_count` and the address pointer.
- **LOAD:**
  - `byte_ready`=1.
  - Accept condition: `byte_valid`&`byte_ready`. On accept:
    - `ram_addr`←pointer, `ram_data`←`byte_data`, `ram_we`←1 for the next cycle only.
    - pointer and `word_count` increment by 1.
  - Back-to-back accepts every cycle are legal.
  - Load ends on an accept with `byte_last`=1, or on the 16th accept (pointer 15) regardless of `byte_last`. Either case → FLUSH with hold counter = CLR_HOLD.
  - `start` is ignored in LOAD.
  - RAM addresses not written keep their prior contents.
- **FLUSH:**
  - Outputs: `byte_ready`=0, `run_prog`=0, `cpu_clr`=0.
  - The final write strobe drains in the first FLUSH cycle.
  - The counter decrements each cycle; at 0 → RUN.
- **RUN:**
  - Outputs: `run_prog`=1, `cpu_clr`=1.
  - `cpu_halt`=1 → HALTED.
  - `start`=1 → LOAD (abort). `start` takes priority over `cpu_halt` in the same cycle.
- **HALTED:**
  - Outputs: `run_prog`=1, `cpu_clr`=1 (output register preserved), `done`=1.
  - `start` → LOAD.
- **Entering LOAD from RUN/HALTED:**
  - `cpu_clr`←0 and `run_prog`←0 on the same edge.
  - `done`←0, `word_count`←0.
- **Pointer wrap:** the pointer never wraps within a load; the 16th accept forces FLUSH.

## Timing
- **Reset values:** state IDLE, `run_prog`=0, `cpu_clr`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `busy`=0, `done`=0, `word_count`=0.
- **Reset mid-LOAD:** an in-flight `ram_we` is cleared immediately (asynchronously). The partial RAM image remains.
- **Start latency:**
  - `start` sampled high at edge k → LOAD from k.
  - `byte_ready`=1 in cycle k+1.
  - The earliest accept is at edge k+1.
- **Write latency:** byte accepted at edge j → `ram_we`=1 with `ram_addr`/`ram_data` valid during cycle j..j+1, deasserted at edge j+1 unless another accept occurs.
- **Release latency:** last accept at edge j → FLUSH for CLR_HOLD cycles → `cpu_clr`=1 and `run_prog`=1 from edge j+CLR_HOLD.
- **Halt latency:** `cpu_halt` sampled at edge h → `done`=1 from h.
- **Mode-switch safety:** `ram_we` and `run_prog`=1 are never high in the same cycle.

## Test plan
- **Full 16-byte load:** reset; pulse `start`; stream 0x10..0x1F with `byte_valid` held high → 16 `ram_we` pulses on addresses 0..15 with matching data, `word_count`=16, `run_prog`=1 exactly CLR_HOLD=2 cycles after the last accept.
- **Short load with gaps:** stream 3 bytes 0x0E, 0xE0, 0xF0 with idle cycles between them, last one flagged `byte_last` → writes only to addresses 0..2, `word_count`=3, then RUN.
- **Halt and reload:** in RUN, assert `cpu_halt` → `done`=1 and `cpu_clr` stays 1. Pulse `start` → `cpu_clr`=0, `run_prog`=0, `done`=0 on the same edge; new load begins at address 0.
- **Priority and ignore rules:** in RUN, assert `start` and `cpu_halt` together → LOAD, `done` never asserts. `start` during LOAD → ignored, pointer not reset.
- **Async reset mid-load:** drop `CLR` between edges after 5 accepts → all outputs at reset values immediately, `ram_we`=0 with no partial strobe.
- **Safety invariant:** assertion checking `ram_we`&`run_prog` is never 1 in any scenario.
